td_init_ctrl: RTL and testbench
===============================

# td_init_ctrl

Bring-up and supervision controller for the external BT.656 TV decoder. After system reset it holds the decoder in hardware reset, then releases it and waits for power-up. It then writes a register table to the decoder through the shared I2C write master and waits for video lock. In service it monitors lock and re-runs the sequence on errors or on request. The block sits between the top-level clock/reset domain, the decoder's reset pin, the I2C master and the BT.656 capture path, which gates on `ready`.

## Interface
Parameters:
- RST_LOW_CYCLES, 700000: cycles `nTDreset` is held low per sequence.
- RST_WAIT_CYCLES, 700000: cycles after `nTDreset` release before the first I2C write.
- NUM_REGS, 16: number of table entries (1..256).
- DEV_ADDR, 8'h40: 8-bit I2C write address of the decoder.
- LOCK_STABLE, 1024: consecutive synced-lock cycles required to enter RUN.
- LOCK_TIMEOUT, 4000000: maximum cycles in LOCK_WAIT.
- MAX_RETRIES, 3: full-sequence retries before ERROR.

Ports:
- clock  in  1  system clock; the only clock.
- nreset  in  1  one clock; reset is asynchronous and active-low.
- start  in  1  single-cycle re-initialise request.
- nTDreset  out  1  decoder hardware reset, active-low, registered.
- tbl_addr  out  8  table index.
- tbl_data  in  16  table entry: [15:8] register, [7:0] value; valid 1 cycle after `tbl_addr`.
- wr_valid  out  1  I2C write request.
- wr_ready  in  1  I2C master accepts the request.
- wr_dev / wr_reg / wr_data  out  8 each  device address, register, value.
- wr_done  in  1  one-cycle pulse at the end of a write.
- wr_err  in  1  NACK flag, qualified by `wr_done`.
- td_lock  in  1  decoder lock status, asynchronous.
- ready  out  1  decoder configured and locked.
- error  out  1  retries exhausted.
- retry_cnt  out  2  retries used in the current attempt chain.

## Operation
- States: RST_ASSERT, RST_WAIT, CFG_FETCH, CFG_ISSUE, CFG_WAIT, LOCK_WAIT, RUN, ERROR.
- Reset values (while `nreset`=0):
  - state RST_ASSERT, counter 0, index 0.
  - `nTDreset`=0, `wr_valid`=0, `ready`=0, `error`=0, `retry_cnt`=0.
  - `tbl_addr`=0, `wr_reg`/`wr_data`=0, `wr_dev`=DEV_ADDR.
- RST_ASSERT: `nTDreset`=0 and the counter increments. At count RST_LOW_CYCLES-1: counter clears, `nTDreset` goes to 1 and the state moves to RST_WAIT.
- RST_WAIT: counts RST_WAIT_CYCLES, then goes to CFG_FETCH with index 0.
- CFG_FETCH: drives `tbl_addr`=index and waits one cycle. It then latches `tbl_data` into `wr_reg`/`wr_data` and moves to CFG_ISSUE.
- CFG_ISSUE: `wr_valid`=1 with stable data until a cycle where `wr_ready`=1. It then drops `wr_valid` and moves to CFG_WAIT.
- CFG_WAIT: waits for `wr_done`.
  - `wr_done` with `wr_err`=1: retry.
  - Otherwise, if index = NUM_REGS-1: go to LOCK_WAIT.
  - Otherwise: index+1, go to CFG_FETCH.
  - `wr_done` arriving while in CFG_ISSUE is ignored.
- `td_lock` passes through a 2-FF synchroniser to produce `lock_s`.
- LOCK_WAIT: a stable counter increments while `lock_s`=1 and clears while `lock_s`=0.
  - Stable count reaches LOCK_STABLE: go to RUN.
  - Timeout counter reaches LOCK_TIMEOUT: retry.
- RUN: `ready`=1. When `lock_s`=0, `ready` drops the next cycle and the state returns to LOCK_WAIT with both counters cleared. There is no reconfiguration and `retry_cnt` is unchanged.
- Retry:
  - If `retry_cnt` < MAX_RETRIES: `retry_cnt`+1 and go to RST_ASSERT.
  - Otherwise go to ERROR.
- ERROR: `error`=1 and `nTDreset`=1. The block stays in ERROR until `start` or `nreset`.
- `start` applies in any state and has priority over every other transition. It causes:
  - `retry_cnt`, `error`, `ready` and `wr_valid` cleared;
  - state RST_ASSERT with counter 0 and `nTDreset`=0 on the next cycle.
- `start` during CFG_WAIT abandons the outstanding write. A later `wr_done` outside CFG_WAIT is ignored.
- Counters are 24 bit; every cycle parameter must be < 2^24.

## Timing
- After `nreset` deasserts, `nTDreset` is low for exactly RST_LOW_CYCLES rising edges, then high.
- First `wr_valid` is asserted RST_WAIT_CYCLES+2 cycles after `nTDreset` rises: one cycle for FETCH and one for the latch.
- Each table entry costs 2 cycles, plus the `wr_ready` wait, plus the master's write duration.
- `lock_s` lags `td_lock` by 2 cycles.
- `ready` rises LOCK_STABLE cycles after `lock_s` rises. It falls 1 cycle after `lock_s` falls, i.e. 3 cycles after `td_lock`.
- All outputs are registered.

## Test plan
- Bring-up with RST_LOW_CYCLES=10, RST_WAIT_CYCLES=5, NUM_REGS=3 and an ideal master (`wr_ready`=1, `wr_done` 4 cycles after accept). Required:
  - `nTDreset` low for 10 cycles;
  - three writes whose reg/data match table entries 0..2, with `wr_dev`=8'h40;
  - with `td_lock`=1 and LOCK_STABLE=8, `ready`=1.
- Backpressure: `wr_ready` held low for 20 cycles. Required: `wr_valid` stays high with stable `wr_reg`/`wr_data`, and exactly one write is accepted.
- NACK on entry 1 with MAX_RETRIES=3. Required:
  - `retry_cnt`=1;
  - `nTDreset` pulses low for 10 cycles;
  - the sequence restarts at index 0.
  After 4 consecutive NACKs: `error`=1, `nTDreset`=1, no further `wr_valid`.
- Lock timeout: `td_lock`=0 with LOCK_TIMEOUT=50. Required: a retry after 50 cycles in LOCK_WAIT. `td_lock` glitching low for 1 cycle at stable count 7 restarts the stable count.
- Lock loss in RUN: `td_lock` falls. Required: `ready`=0 3 cycles later, no new writes, and `ready` back after LOCK_STABLE cycles of lock.
- `start` asserted mid-CFG_WAIT and again in ERROR. Required: `nTDreset`=0 the next cycle, `retry_cnt`=0, `error`=0, and the stale `wr_done` is ignored. Asserting `nreset` mid-RUN forces every output to its reset value asynchronously.

Source files
------------

// File: rtl/td_init_ctrl.sv
// Bring-up and supervision controller for an external BT.656 TV decoder: pulses the
// decoder reset, writes the register table over the shared I2C write master, waits
// for video lock, then supervises lock and restarts the sequence on errors or request.
// Ports: clock/nreset (async active-low), start (re-init), nTDreset (decoder reset),
//   tbl_addr/tbl_data (table ROM, 1-cycle read), wr_* (I2C write request/response),
//   td_lock (async lock status), ready/error/retry_cnt (status).
module td_init_ctrl #(
  parameter int          RST_LOW_CYCLES  = 700000,
  parameter int          RST_WAIT_CYCLES = 700000,
  parameter int          NUM_REGS        = 16,
  parameter logic [7:0]  DEV_ADDR        = 8'h40,
  parameter int          LOCK_STABLE     = 1024,
  parameter int          LOCK_TIMEOUT    = 4000000,
  parameter int          MAX_RETRIES     = 3
) (
  input  logic        clock,
  input  logic        nreset,
  input  logic        start,
  output logic        nTDreset,
  output logic [7:0]  tbl_addr,
  input  logic [15:0] tbl_data,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [7:0]  wr_dev,
  output logic [7:0]  wr_reg,
  output logic [7:0]  wr_data,
  input  logic        wr_done,
  input  logic        wr_err,
  input  logic        td_lock,
  output logic        ready,
  output logic        error,
  output logic [1:0]  retry_cnt
);

  typedef enum logic [2:0] {
    RST_ASSERT, RST_WAIT, CFG_FETCH, CFG_ISSUE, CFG_WAIT, LOCK_WAIT, RUN, ERROR
  } state_t;

  // Terminal counts: a counter "reaches" N on the cycle it holds N-1.
  localparam logic [23:0] RST_LOW_LAST  = 24'(RST_LOW_CYCLES - 1);
  localparam logic [23:0] RST_WAIT_LAST = 24'(RST_WAIT_CYCLES - 1);
  localparam logic [23:0] STABLE_LAST   = 24'(LOCK_STABLE - 1);
  localparam logic [23:0] TIMEOUT_LAST  = 24'(LOCK_TIMEOUT - 1);
  localparam logic [7:0]  LAST_IDX      = 8'(NUM_REGS - 1);
  localparam logic [1:0]  MAX_R         = 2'(MAX_RETRIES);

  state_t      state, state_n;
  logic [23:0] cnt, cnt_n;               // reset/wait counter, reused as lock timeout
  logic [23:0] stable_cnt, stable_cnt_n;
  logic [7:0]  tbl_addr_n, wr_reg_n, wr_data_n;
  logic [1:0]  retry_n;
  logic        fetch_ph, fetch_ph_n;     // 0: address presented, 1: ROM data valid
  logic        nTDreset_n, wr_valid_n, ready_n, error_n;
  logic        do_retry;
  logic        lock_meta, lock_s;

  // Device address never changes; it is a constant, not state.
  assign wr_dev = DEV_ADDR;

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= td_lock;
      lock_s    <= lock_meta;
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state      <= RST_ASSERT;
      cnt        <= '0;
      stable_cnt <= '0;
      fetch_ph   <= 1'b0;
      tbl_addr   <= '0;
      wr_reg     <= '0;
      wr_data    <= '0;
      nTDreset   <= 1'b0;
      wr_valid   <= 1'b0;
      ready      <= 1'b0;
      error      <= 1'b0;
      retry_cnt  <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      stable_cnt <= stable_cnt_n;
      fetch_ph   <= fetch_ph_n;
      tbl_addr   <= tbl_addr_n;
      wr_reg     <= wr_reg_n;
      wr_data    <= wr_data_n;
      nTDreset   <= nTDreset_n;
      wr_valid   <= wr_valid_n;
      ready      <= ready_n;
      error      <= error_n;
      retry_cnt  <= retry_n;
    end
  end

  // tbl_addr doubles as the table index.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    stable_cnt_n = stable_cnt;
    fetch_ph_n   = fetch_ph;
    tbl_addr_n   = tbl_addr;
    wr_reg_n     = wr_reg;
    wr_data_n    = wr_data;
    nTDreset_n   = nTDreset;
    wr_valid_n   = wr_valid;
    ready_n      = ready;
    error_n      = error;
    retry_n      = retry_cnt;
    do_retry     = 1'b0;

    unique case (state)
      RST_ASSERT: begin
        nTDreset_n = 1'b0;
        if (cnt == RST_LOW_LAST) begin
          cnt_n      = '0;
          nTDreset_n = 1'b1;
          state_n    = RST_WAIT;
        end else begin
          cnt_n = cnt + 24'd1;
        end
      end
      RST_WAIT: begin
        if (cnt == RST_WAIT_LAST) begin
          cnt_n      = '0;
          tbl_addr_n = '0;
          fetch_ph_n = 1'b0;
          state_n    = CFG_FETCH;
        end else begin
          cnt_n = cnt + 24'd1;
        end
      end
      CFG_FETCH: begin
        if (!fetch_ph) begin
          fetch_ph_n = 1'b1;
        end else begin
          fetch_ph_n = 1'b0;
          wr_reg_n   = tbl_data[15:8];
          wr_data_n  = tbl_data[7:0];
          wr_valid_n = 1'b1;
          state_n    = CFG_ISSUE;
        end
      end
      CFG_ISSUE: begin
        // wr_done here belongs to an abandoned write and is ignored.
        if (wr_ready) begin
          wr_valid_n = 1'b0;
          state_n    = CFG_WAIT;
        end
      end
      CFG_WAIT: begin
        if (wr_done) begin
          if (wr_err) begin
            do_retry = 1'b1;
          end else if (tbl_addr == LAST_IDX) begin
            cnt_n        = '0;
            stable_cnt_n = '0;
            state_n      = LOCK_WAIT;
          end else begin
            tbl_addr_n = tbl_addr + 8'd1;
            state_n    = CFG_FETCH;
          end
        end
      end
      LOCK_WAIT: begin
        if (lock_s && stable_cnt == STABLE_LAST) begin
          ready_n = 1'b1;
          state_n = RUN;
        end else begin
          stable_cnt_n = lock_s ? stable_cnt + 24'd1 : '0;
          if (cnt == TIMEOUT_LAST) begin
            do_retry = 1'b1;
          end else begin
            cnt_n = cnt + 24'd1;
          end
        end
      end
      RUN: begin
        // Lock loss only re-qualifies lock; the decoder keeps its configuration.
        if (!lock_s) begin
          ready_n      = 1'b0;
          cnt_n        = '0;
          stable_cnt_n = '0;
          state_n      = LOCK_WAIT;
        end
      end
      ERROR: begin
        error_n    = 1'b1;
        nTDreset_n = 1'b1;
      end
      default: state_n = RST_ASSERT;
    endcase

    if (do_retry) begin
      ready_n = 1'b0;
      if (retry_cnt < MAX_R) begin
        retry_n    = retry_cnt + 2'd1;
        cnt_n      = '0;
        nTDreset_n = 1'b0;
        state_n    = RST_ASSERT;
      end else begin
        error_n    = 1'b1;
        nTDreset_n = 1'b1;
        state_n    = ERROR;
      end
    end

    // Re-initialise request overrides every other transition.
    if (start) begin
      retry_n      = '0;
      error_n      = 1'b0;
      ready_n      = 1'b0;
      wr_valid_n   = 1'b0;
      cnt_n        = '0;
      stable_cnt_n = '0;
      fetch_ph_n   = 1'b0;
      nTDreset_n   = 1'b0;
      state_n      = RST_ASSERT;
    end
  end

endmodule

// File: tb/tb_td_init_ctrl.sv
// Self-checking bench for td_init_ctrl: random register table and lock timing,
// an I2C master model answering accepted writes, and spec-derived expectations.
module tb_td_init_ctrl;
  localparam int         RST_LOW  = 10;
  localparam int         RST_WAIT = 5;
  localparam int         NREGS    = 3;
  localparam int         STABLE   = 8;
  localparam int         TIMEOUT  = 50;
  localparam int         MAXR     = 3;
  localparam logic [7:0] DEV      = 8'h40;

  logic        clock, nreset, start, nTDreset;
  logic [7:0]  tbl_addr;
  logic [15:0] tbl_data;
  logic        wr_valid, wr_ready, wr_done, wr_err, td_lock, ready, error;
  logic [7:0]  wr_dev, wr_reg, wr_data;
  logic [1:0]  retry_cnt;

  td_init_ctrl #(
    .RST_LOW_CYCLES(RST_LOW), .RST_WAIT_CYCLES(RST_WAIT), .NUM_REGS(NREGS),
    .DEV_ADDR(DEV), .LOCK_STABLE(STABLE), .LOCK_TIMEOUT(TIMEOUT), .MAX_RETRIES(MAXR)
  ) dut (
    .clock(clock), .nreset(nreset), .start(start), .nTDreset(nTDreset),
    .tbl_addr(tbl_addr), .tbl_data(tbl_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_dev(wr_dev), .wr_reg(wr_reg), .wr_data(wr_data), .wr_done(wr_done),
    .wr_err(wr_err), .td_lock(td_lock), .ready(ready), .error(error),
    .retry_cnt(retry_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] tbl [0:255];
  logic [7:0]  rom_a;
  logic [23:0] acc_q [$];   // {dev, reg, data} of every accepted write
  logic [23:0] exp_q [$];
  int          done_delay = 4;
  bit          nack_en    = 0;
  logic [7:0]  nack_entry = 8'd1;
  int          pend       = 0;
  bit          pend_err   = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Synchronous table ROM: data for an address appears one cycle after it.
  initial begin
    tbl_data = '0;
    forever begin
      @(negedge clock);
      rom_a = tbl_addr;
      @(posedge clock);
      #1 tbl_data = tbl[rom_a];
    end
  end

  // I2C master model: logs each write about to be accepted and answers with
  // wr_done done_delay cycles after the accepting edge.
  initial begin
    wr_done = 1'b0;
    wr_err  = 1'b0;
    forever begin
      @(negedge clock);
      wr_done = 1'b0;
      wr_err  = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          wr_done = 1'b1;
          wr_err  = pend_err;
        end
      end
      if (wr_valid === 1'b1 && wr_ready === 1'b1) begin
        acc_q.push_back({wr_dev, wr_reg, wr_data});
        pend     = done_delay;
        pend_err = nack_en && (tbl_addr == nack_entry);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Rising edges seen while nTDreset is low, starting from a low sample.
  task automatic measure_low(output int n);
    n = 0;
    while (nTDreset === 1'b0 && n < 1000) begin
      n++;
      tick();
    end
  endtask

  // Reference sequence: each attempt writes entries 0..last in table order.
  task automatic build_exp(input int attempts, input int last);
    exp_q.delete();
    for (int a = 0; a < attempts; a++)
      for (int i = 0; i <= last; i++)
        exp_q.push_back({DEV, tbl[i]});
  endtask

  task automatic test_reset();
    nreset = 1'b0; start = 1'b0; td_lock = 1'b0; wr_ready = 1'b1;
    for (int i = 0; i < 256; i++) tbl[i] = 16'($urandom);
    repeat (3) tick();
    n_checks++; if ({nTDreset, wr_valid, ready, error, retry_cnt} !== 6'b0)
      $display("FAIL reset_ctrl: got %b want 000000", {nTDreset, wr_valid, ready, error, retry_cnt}); else n_pass++;
    n_checks++; if (tbl_addr !== 8'h00) $display("FAIL reset_addr: got %0h want 0", tbl_addr); else n_pass++;
    n_checks++; if ({wr_reg, wr_data} !== 16'h0) $display("FAIL reset_wr: got %0h want 0", {wr_reg, wr_data}); else n_pass++;
    n_checks++; if (wr_dev !== DEV) $display("FAIL reset_dev: got %0h want %0h", wr_dev, DEV); else n_pass++;
  endtask

  task automatic test_bringup();
    int n;
    td_lock = 1'b1;
    acc_q.delete();
    build_exp(1, NREGS - 1);
    #2 nreset = 1'b1;
    measure_low(n);
    n_checks++; if (n != RST_LOW) $display("FAIL bringup_low: got %0d want %0d", n, RST_LOW); else n_pass++;
    n = 0;
    while (wr_valid !== 1'b1 && n < 100) begin tick(); n++; end
    n_checks++; if (n != RST_WAIT + 2) $display("FAIL first_valid: got %0d want %0d", n, RST_WAIT + 2); else n_pass++;
    n = 0;
    while (ready !== 1'b1 && n < 300) begin tick(); n++; end
    n_checks++; if (ready !== 1'b1) $display("FAIL bringup_ready: got %b want 1", ready); else n_pass++;
    n_checks++; if (acc_q.size() != exp_q.size()) $display("FAIL bringup_nwr: got %0d want %0d", acc_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++) begin
      n_checks++; if (acc_q[i] !== exp_q[i]) $display("FAIL bringup_wr%0d: got %0h want %0h", i, acc_q[i], exp_q[i]); else n_pass++;
    end
    n_checks++; if ({error, retry_cnt, nTDreset} !== 4'b0001) $display("FAIL bringup_status: got %b want 0001", {error, retry_cnt, nTDreset}); else n_pass++;
  endtask

  task automatic test_lock_loss();
    int n, nacc, lowlen;
    nacc = acc_q.size();
    lowlen = $urandom_range(4, 20);
    td_lock = 1'b0;
    tick(); tick();
    n_checks++; if (ready !== 1'b1) $display("FAIL loss_ready_t2: got %b want 1", ready); else n_pass++;
    tick();
    n_checks++; if (ready !== 1'b0) $display("FAIL loss_ready_t3: got %b want 0", ready); else n_pass++;
    repeat (lowlen - 3) tick();
    td_lock = 1'b1;
    n = 0;
    while (ready !== 1'b1 && n < 100) begin tick(); n++; end
    n_checks++; if (n != 2 + STABLE) $display("FAIL loss_relock: got %0d want %0d", n, 2 + STABLE); else n_pass++;
    n_checks++; if (acc_q.size() != nacc) $display("FAIL loss_nowrites: got %0d want %0d", acc_q.size(), nacc); else n_pass++;
    n_checks++; if ({nTDreset, retry_cnt} !== 3'b100) $display("FAIL loss_status: got %b want 100", {nTDreset, retry_cnt}); else n_pass++;
  endtask

  task automatic test_lock_glitch();
    int first;
    td_lock = 1'b0;
    repeat (5) tick();
    td_lock = 1'b1;
    first = -1;
    // Low for one cycle exactly when the stable count sits one short of LOCK_STABLE.
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == STABLE - 1) td_lock = 1'b0;
      if (k == STABLE) td_lock = 1'b1;
      if (ready === 1'b1 && first < 0) first = k;
    end
    n_checks++; if (first != 2 + 2 * STABLE) $display("FAIL glitch_ready: got %0d want %0d", first, 2 + 2 * STABLE); else n_pass++;
  endtask

  task automatic test_lock_timeout();
    int n;
    td_lock = 1'b0;
    n = 0;
    while (nTDreset === 1'b1 && n < 200) begin tick(); n++; end
    n_checks++; if (n != 3 + TIMEOUT) $display("FAIL timeout_cycles: got %0d want %0d", n, 3 + TIMEOUT); else n_pass++;
    n_checks++; if (retry_cnt !== 2'd1) $display("FAIL timeout_retry: got %0d want 1", retry_cnt); else n_pass++;
    acc_q.delete();
    build_exp(1, NREGS - 1);
    measure_low(n);
    n_checks++; if (n != RST_LOW) $display("FAIL timeout_low: got %0d want %0d", n, RST_LOW); else n_pass++;
    td_lock = 1'b1;
    n = 0;
    while (ready !== 1'b1 && n < 300) begin tick(); n++; end
    n_checks++; if (ready !== 1'b1) $display("FAIL timeout_reready: got %b want 1", ready); else n_pass++;
    n_checks++; if (acc_q != exp_q) $display("FAIL timeout_writes: got %0d writes want %0d", acc_q.size(), exp_q.size()); else n_pass++;
    n_checks++; if (retry_cnt !== 2'd1) $display("FAIL timeout_retry_kept: got %0d want 1", retry_cnt); else n_pass++;
  endtask

  task automatic test_backpressure();
    int n, bad;
    wr_ready = 1'b0;
    acc_q.delete();
    start = 1'b1; tick(); start = 1'b0;
    n_checks++; if (retry_cnt !== 2'd0) $display("FAIL bp_retry_clr: got %0d want 0", retry_cnt); else n_pass++;
    n = 0;
    while (wr_valid !== 1'b1 && n < 100) begin tick(); n++; end
    n_checks++; if (wr_valid !== 1'b1) $display("FAIL bp_valid: got %b want 1", wr_valid); else n_pass++;
    bad = 0;
    repeat (20) begin
      tick();
      if (wr_valid !== 1'b1 || {wr_reg, wr_data} !== tbl[0]) bad++;
    end
    n_checks++; if (bad != 0) $display("FAIL bp_stable: got %0d bad cycles want 0", bad); else n_pass++;
    wr_ready = 1'b1; tick(); wr_ready = 1'b0;
    n_checks++; if (wr_valid !== 1'b0) $display("FAIL bp_drop: got %b want 0", wr_valid); else n_pass++;
    repeat (3) tick();
    n_checks++; if (acc_q.size() != 1) $display("FAIL bp_one_accept: got %0d want 1", acc_q.size()); else n_pass++;
    wr_ready = 1'b1;
    build_exp(1, NREGS - 1);
    n = 0;
    while (ready !== 1'b1 && n < 300) begin tick(); n++; end
    n_checks++; if (acc_q != exp_q) $display("FAIL bp_writes: got %0d writes want %0d", acc_q.size(), exp_q.size()); else n_pass++;
  endtask

  task automatic test_nack();
    int n, nacc, seen;
    nack_en = 1'b1;
    nack_entry = 8'd1;
    acc_q.delete();
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (nTDreset !== 1'b1 && n < 100) begin tick(); n++; end
    n = 0;
    while (nTDreset !== 1'b0 && n < 200) begin tick(); n++; end
    n_checks++; if (retry_cnt !== 2'd1) $display("FAIL nack_retry1: got %0d want 1", retry_cnt); else n_pass++;
    n_checks++; if (acc_q.size() != 2) $display("FAIL nack_nwr1: got %0d want 2", acc_q.size()); else n_pass++;
    measure_low(n);
    n_checks++; if (n != RST_LOW) $display("FAIL nack_low: got %0d want %0d", n, RST_LOW); else n_pass++;
    n = 0;
    while (acc_q.size() < 3 && n < 100) begin tick(); n++; end
    n_checks++; if (acc_q.size() < 3 || acc_q[2] !== {DEV, tbl[0]})
      $display("FAIL nack_restart: got %0d writes, want entry0 %0h", acc_q.size(), {DEV, tbl[0]}); else n_pass++;
    n = 0;
    while (error !== 1'b1 && n < 1000) begin tick(); n++; end
    n_checks++; if ({error, nTDreset} !== 2'b11) $display("FAIL nack_error: got %b want 11", {error, nTDreset}); else n_pass++;
    n_checks++; if (retry_cnt !== 2'(MAXR)) $display("FAIL nack_retry_max: got %0d want %0d", retry_cnt, MAXR); else n_pass++;
    build_exp(MAXR + 1, 1);
    n_checks++; if (acc_q != exp_q) $display("FAIL nack_writes: got %0d writes want %0d", acc_q.size(), exp_q.size()); else n_pass++;
    nacc = acc_q.size();
    seen = 0;
    repeat (60) begin tick(); if (wr_valid !== 1'b0) seen++; end
    n_checks++; if (seen != 0 || acc_q.size() != nacc) $display("FAIL nack_quiet: got %0d valid cycles want 0", seen); else n_pass++;
    nack_en = 1'b0;
  endtask

  task automatic test_start();
    int n;
    start = 1'b1; tick(); start = 1'b0;
    n_checks++; if ({nTDreset, error, retry_cnt} !== 4'b0000) $display("FAIL start_err: got %b want 0000", {nTDreset, error, retry_cnt}); else n_pass++;
    done_delay = 8;
    acc_q.delete();
    n = 0;
    while (acc_q.size() < 1 && n < 200) begin tick(); n++; end
    tick();
    start = 1'b1; tick(); start = 1'b0;
    n_checks++; if ({nTDreset, wr_valid, ready} !== 3'b000) $display("FAIL start_wait: got %b want 000", {nTDreset, wr_valid, ready}); else n_pass++;
    acc_q.delete();
    done_delay = 4;
    build_exp(1, NREGS - 1);
    measure_low(n);
    n_checks++; if (n != RST_LOW) $display("FAIL start_low: got %0d want %0d", n, RST_LOW); else n_pass++;
    n = 0;
    while (ready !== 1'b1 && n < 300) begin tick(); n++; end
    n_checks++; if (acc_q != exp_q) $display("FAIL start_writes: got %0d writes want %0d", acc_q.size(), exp_q.size()); else n_pass++;
    n_checks++; if ({ready, error, retry_cnt} !== 4'b1000) $display("FAIL start_status: got %b want 1000", {ready, error, retry_cnt}); else n_pass++;
  endtask

  task automatic test_async_reset();
    #3 nreset = 1'b0;
    #1;
    n_checks++; if ({nTDreset, wr_valid, ready, error, retry_cnt} !== 6'b0)
      $display("FAIL areset_ctrl: got %b want 000000", {nTDreset, wr_valid, ready, error, retry_cnt}); else n_pass++;
    n_checks++; if ({tbl_addr, wr_reg, wr_data} !== 24'h0) $display("FAIL areset_data: got %0h want 0", {tbl_addr, wr_reg, wr_data}); else n_pass++;
    n_checks++; if (wr_dev !== DEV) $display("FAIL areset_dev: got %0h want %0h", wr_dev, DEV); else n_pass++;
    tick();
    nreset = 1'b1;
    repeat (3) tick();
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_lock_loss();
    test_lock_glitch();
    test_lock_timeout();
    test_backpressure();
    test_nack();
    test_start();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
